// File: rtl/seq_multiplier_taint.sv
// Radix-2 shift-add sequential multiplier with valid/ready handshake, signed mode,
// optional early termination and 1-bit taint tracking of data and completion timing.
module seq_multiplier_taint #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               start_t,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic               signed_mode_t,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               multiplicand_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               multiplier_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t,
  output logic               out_valid,
  output logic               out_valid_t,
  input  logic               out_ready,
  output logic               busy
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   md_q, md_d;
  logic [PW-1:0]   product_q, product_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            neg_q, neg_d;
  logic            ptaint_q, ptaint_d;
  logic            vtaint_q, vtaint_d;
  logic            product_t_q, product_t_d;
  logic            out_valid_t_q, out_valid_t_d;
  logic            last_calc;

  // Magnitude as an unsigned WIDTH-bit value; the most negative input maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? (-x) : x;
  endfunction

  assign last_calc = (count_q == CW'(WIDTH - 1)) ||
                     (EARLY_EXIT && ((mr_q >> 1) == '0));

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    md_d          = md_q;
    mr_d          = mr_q;
    count_d       = count_q;
    neg_d         = neg_q;
    ptaint_d      = ptaint_q;
    vtaint_d      = vtaint_q;
    product_d     = product_q;
    product_t_d   = product_t_q;
    out_valid_t_d = out_valid_t_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          md_d     = {{WIDTH{1'b0}}, magnitude(multiplicand, signed_mode)};
          mr_d     = magnitude(multiplier, signed_mode);
          acc_d    = '0;
          count_d  = '0;
          neg_d    = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          ptaint_d = multiplicand_t | multiplier_t | signed_mode_t | start_t;
          vtaint_d = start_t | (EARLY_EXIT & multiplier_t);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        if (mr_q[0]) acc_d = acc_q + md_q;
        md_d    = md_q << 1;
        mr_d    = mr_q >> 1;
        count_d = count_q + CW'(1);
        if (last_calc) state_d = S_SIGN;
      end
      S_SIGN: begin
        product_d     = neg_q ? (-acc_q) : acc_q;
        product_t_d   = ptaint_q;
        out_valid_t_d = vtaint_q;
        state_d       = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      md_q          <= '0;
      mr_q          <= '0;
      count_q       <= '0;
      neg_q         <= 1'b0;
      ptaint_q      <= 1'b0;
      vtaint_q      <= 1'b0;
      product_q     <= '0;
      product_t_q   <= 1'b0;
      out_valid_t_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      md_q          <= md_d;
      mr_q          <= mr_d;
      count_q       <= count_d;
      neg_q         <= neg_d;
      ptaint_q      <= ptaint_d;
      vtaint_q      <= vtaint_d;
      product_q     <= product_d;
      product_t_q   <= product_t_d;
      out_valid_t_q <= out_valid_t_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q == S_CALC) || (state_q == S_SIGN);
  assign out_valid   = (state_q == S_DONE);
  assign product     = product_q;
  assign product_t   = product_t_q;
  assign out_valid_t = out_valid_t_q;
endmodule

// File: tb/tb_seq_multiplier_taint.sv
// Bench for seq_multiplier_taint at WIDTH=8, one instance per EARLY_EXIT setting,
// checked against an arithmetic reference of product, latency and taint.
module tb_seq_multiplier_taint;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, ordy0, ordy1;
  logic sm, sm_t, st_t, a_t, b_t;
  logic [W-1:0] a, b;

  logic           irdy0, irdy1, busy0, busy1, ov0, ov1, ovt0, ovt1, pt0, pt1;
  logic [2*W-1:0] prod0, prod1;

  int total = 0;
  int bad   = 0;
  logic sel = 1'b0;

  wire [2*W-1:0] m_prod = sel ? prod1 : prod0;
  wire           m_pt   = sel ? pt1   : pt0;
  wire           m_ovt  = sel ? ovt1  : ovt0;
  wire           m_ov   = sel ? ov1   : ov0;
  wire           m_irdy = sel ? irdy1 : irdy0;
  wire           m_busy = sel ? busy1 : busy0;

  always #5 clk = ~clk;

  seq_multiplier_taint #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .start_t(st_t), .in_ready(irdy0),
    .signed_mode(sm), .signed_mode_t(sm_t), .multiplicand(a), .multiplicand_t(a_t),
    .multiplier(b), .multiplier_t(b_t), .product(prod0), .product_t(pt0),
    .out_valid(ov0), .out_valid_t(ovt0), .out_ready(ordy0), .busy(busy0));

  seq_multiplier_taint #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .start_t(st_t), .in_ready(irdy1),
    .signed_mode(sm), .signed_mode_t(sm_t), .multiplicand(a), .multiplicand_t(a_t),
    .multiplier(b), .multiplier_t(b_t), .product(prod1), .product_t(pt1),
    .out_valid(ov1), .out_valid_t(ovt1), .out_ready(ordy1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic smv, input logic [W-1:0] av, bv);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(av);
    sb = $signed(bv);
    if (smv) return sa * sb;
    return {{W{1'b0}}, av} * {{W{1'b0}}, bv};
  endfunction

  // Edges from the accepting edge (counted as edge 1) to the edge after which out_valid is high.
  function automatic int ref_lat(input bit ee, input logic smv, input logic [W-1:0] bv);
    logic [W-1:0] mag;
    int k;
    if (!ee) return W + 2;
    mag = (smv && bv[W-1]) ? (~bv + 8'd1) : bv;
    k = 1;
    for (int i = 0; i < W; i++) if (mag[i]) k = i + 1;
    return k + 2;
  endfunction

  // Called at a negedge with the selected DUT idle; returns at a negedge with it idle again.
  task automatic run(input bit s, input logic smv, input logic [W-1:0] av, bv,
                     input logic [3:0] tv, input int hold);
    logic [2*W-1:0] ep;
    int lat, n;
    ep  = ref_prod(smv, av, bv);
    lat = ref_lat(s, smv, bv);
    sel = s;
    #1;
    sm = smv; a = av; b = bv;
    st_t = tv[3]; sm_t = tv[2]; a_t = tv[1]; b_t = tv[0];
    if (s) begin start1 = 1'b1; ordy1 = (hold == 0); end
    else   begin start0 = 1'b1; ordy0 = (hold == 0); end
    chk("in_ready_before_start", m_irdy, 1);
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    n = 1;
    while (1) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (m_ov || n > 40) break;
    end
    chk("latency", n, lat);
    chk("product", m_prod, ep);
    chk("product_t", m_pt, |tv);
    chk("out_valid_t", m_ovt, tv[3] | (s & tv[0]));
    chk("busy_in_done", m_busy, 0);
    chk("in_ready_in_done", m_irdy, 0);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        if (h == 1) begin
          a = ~av; b = ~bv;
          if (s) start1 = 1'b1; else start0 = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        chk("hold_out_valid", m_ov, 1);
        chk("hold_product", m_prod, ep);
        chk("hold_in_ready", m_irdy, 0);
      end
      start0 = 1'b0; start1 = 1'b0;
      if (s) ordy1 = 1'b1; else ordy0 = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    chk("out_valid_after_hs", m_ov, 0);
    chk("in_ready_after_hs", m_irdy, 1);
    chk("product_kept", m_prod, ep);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen_ov;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
    sm = 1'b0; sm_t = 1'b0; st_t = 1'b0; a_t = 1'b0; b_t = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready0", irdy0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_out_valid0", ov0, 0);
    chk("rst_product0", prod0, 0);
    chk("rst_taints0", {pt0, ovt0}, 0);
    chk("rst_in_ready1", irdy1, 1);
    chk("rst_out_valid1", ov1, 0);
    chk("rst_product1", prod1, 0);
    rst = 1'b0;
    @(negedge clk);

    run(0, 1'b0, 8'd13, 8'd11, 4'b0000, 0);
    run(0, 1'b1, 8'h80, 8'h80, 4'b0000, 0);
    run(1, 1'b1, 8'h80, 8'h80, 4'b0000, 0);
    run(0, 1'b1, 8'hFD, 8'd5, 4'b0000, 0);
    run(1, 1'b1, 8'hFD, 8'd5, 4'b0000, 0);
    run(0, 1'b0, 8'hFF, 8'hFF, 4'b0000, 0);
    run(1, 1'b0, 8'hFF, 8'hFF, 4'b0000, 0);
    run(0, 1'b0, 8'd77, 8'd3, 4'b0001, 0);
    run(1, 1'b0, 8'd77, 8'd3, 4'b0001, 0);
    run(1, 1'b0, 8'd9, 8'd1, 4'b0000, 0);
    run(1, 1'b0, 8'd200, 8'd0, 4'b0000, 0);
    run(0, 1'b0, 8'd200, 8'd0, 4'b0000, 0);
    run(1, 1'b0, 8'd3, 8'h80, 4'b0000, 0);
    run(1, 1'b1, 8'd7, 8'hFF, 4'b1000, 0);
    run(0, 1'b0, 8'd21, 8'd17, 4'b0110, 5);
    run(0, 1'b1, 8'hC4, 8'd37, 4'b0000, 0);
    run(1, 1'b0, 8'd99, 8'd44, 4'b0000, 5);
    run(1, 1'b0, 8'd5, 8'd6, 4'b0000, 0);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] tv;
      tv = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      run(bit'(i % 2), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), tv, 0);
    end

    sel = 1'b0;
    #1;
    sm = 1'b0; a = 8'd250; b = 8'd251; st_t = 1'b1; sm_t = 1'b1; a_t = 1'b1; b_t = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", busy0, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("midrst_in_ready", irdy0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_product", prod0, 0);
    chk("midrst_taints", {pt0, ovt0}, 0);
    rst = 1'b0;
    st_t = 1'b0; sm_t = 1'b0; a_t = 1'b0; b_t = 1'b0;
    seen_ov = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov0) seen_ov = 1'b1;
    end
    chk("no_out_valid_after_rst", seen_ov, 0);
    run(0, 1'b0, 8'd12, 8'd12, 4'b0000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
